// File: rtl/instr_fetch_sequencer.sv
// instr_fetch_sequencer: fetches 16/32-bit instructions over a 16-bit memory port and issues them to the decoder
module instr_fetch_sequencer #(
  parameter int PC_WIDTH = 24,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic                imem_ack,
  input  logic [15:0]         imem_data,
  output logic                dec_valid,
  input  logic                dec_ready,
  output logic [31:0]         dec_instr,
  output logic                dec_is32,
  output logic [PC_WIDTH-1:0] dec_pc,
  input  logic                redirect,
  input  logic [PC_WIDTH-1:0] redirect_pc,
  output logic [15:0]         issue_count
);
  typedef enum logic [1:0] {FLUSH, FETCH_LO, FETCH_HI, ISSUE} state_t;
  state_t state, state_nxt;
  logic [PC_WIDTH-1:0] pc;
  logic fetching, take;
  assign fetching  = state == FETCH_LO || state == FETCH_HI;
  assign take      = fetching && imem_ack && !redirect;
  assign imem_req  = fetching;
  assign imem_addr = pc;
  assign dec_valid = state == ISSUE;
  // next state: a redirect beats acks and handshakes in every state
  always_comb begin
    state_nxt = state;
    if (redirect) state_nxt = FLUSH;
    else case (state)
      FLUSH:    state_nxt = FETCH_LO;
      FETCH_LO: state_nxt = imem_ack ? (imem_data[15] ? FETCH_HI : ISSUE) : FETCH_LO;
      FETCH_HI: state_nxt = imem_ack ? ISSUE : FETCH_HI;
      default:  state_nxt = dec_ready ? FETCH_LO : ISSUE;
    endcase
  end
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= FLUSH;
    else state <= state_nxt;
  // pc, instruction assembly and accepted-instruction counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc          <= RESET_PC;
      dec_instr   <= '0;
      dec_is32    <= 1'b0;
      dec_pc      <= '0;
      issue_count <= '0;
    end else if (redirect) pc <= redirect_pc;
    else if (take) begin
      pc <= pc + 1'b1;
      if (state == FETCH_LO) begin
        dec_pc          <= pc;
        dec_instr[15:0] <= imem_data;
        if (!imem_data[15]) begin
          dec_instr[31:16] <= '0;
          dec_is32         <= 1'b0;
        end
      end else begin
        dec_instr[31:16] <= imem_data;
        dec_is32         <= 1'b1;
      end
    end else if (dec_valid && dec_ready) issue_count <= issue_count + 16'd1;
  end
endmodule

// File: doc/instr_fetch_sequencer.md
# instr_fetch_sequencer

Sequences instruction fetch for the AAP pipeline front end and hands complete instructions to the 16/32-bit decoder. It drives a 16-bit-wide instruction memory port, assembles one- or two-word instructions based on bit 15 of the first word, tracks the program counter, and applies a valid/ready handshake toward the decoder. Branch redirects from execute flush any in-progress fetch.

## Interface
Parameters:
- PC_WIDTH, 24, width of the word-address program counter.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  PC_WIDTH  word address being fetched.
- imem_ack  in  1  memory has returned data for imem_addr this cycle.
- imem_data  in  16  fetched word; valid only when imem_ack=1.
- dec_valid  out  1  dec_instr/dec_is32/dec_pc hold a complete instruction.
- dec_ready  in  1  decoder accepts the instruction this cycle.
- dec_instr  out  32  instruction; [15:0] first word, [31:16] second word (zero for 16-bit).
- dec_is32  out  1  1 = 32-bit instruction.
- dec_pc  out  PC_WIDTH  address of the instruction's first word.
- redirect  in  1  branch taken; restart fetch at redirect_pc.
- redirect_pc  in  PC_WIDTH  new fetch address.
- issue_count  out  16  count of instructions accepted by the decoder; wraps.

## Operation
- States: FLUSH, FETCH_LO, FETCH_HI, ISSUE. All outputs are registered or decoded from state only.
- FLUSH: imem_req=0; any imem_ack is ignored; next state is FETCH_LO.
- FETCH_LO: imem_req=1, imem_addr=pc. On imem_ack, set dec_pc<=pc, dec_instr[15:0]<=imem_data, and pc<=pc+1.
  - If imem_data[15]=0: set dec_instr[31:16]<=0 and dec_is32<=0, then go to ISSUE.
  - Otherwise go to FETCH_HI.
- FETCH_HI: imem_req=1, imem_addr=pc. On imem_ack, set dec_instr[31:16]<=imem_data, dec_is32<=1, pc<=pc+1, then go to ISSUE. Bit 15 of the second word is not examined.
- ISSUE: dec_valid=1. Payload is stable while dec_valid=1 and dec_ready=0. When dec_ready=1: issue_count<=issue_count+1 and go to FETCH_LO.
- imem_req and imem_addr are held stable until imem_ack, except on redirect.
- Redirect takes priority over ack and handshake in every state. On redirect=1:
  - pc<=redirect_pc and next state is FLUSH; dec_valid drops next cycle.
  - A same-cycle imem_ack is discarded.
  - A same-cycle dec_ready does not count as an accepted instruction, and issue_count is unchanged.
- PC arithmetic is modulo 2^PC_WIDTH. A 32-bit instruction whose first word is at all-ones fetches its second word from address 0.
- issue_count wraps from 0xFFFF to 0.

## Timing
- Reset (async assert) values:
  - state=FLUSH, pc=RESET_PC.
  - imem_req=0, imem_addr=RESET_PC.
  - dec_valid=0, dec_instr=0, dec_is32=0, dec_pc=0.
  - issue_count=0.
- First imem_req occurs 1 cycle after reset release (the FLUSH cycle).
- With zero-wait memory (ack in the same cycle as req) and dec_ready=1:
  - 16-bit instruction: 2 cycles per instruction (FETCH_LO, ISSUE).
  - 32-bit instruction: 3 cycles per instruction.
- Memory wait states extend FETCH_LO/FETCH_HI one cycle per cycle with imem_ack=0.
- Redirect to first new imem_req costs 2 cycles (redirect edge, FLUSH).
- Reset asserted mid-fetch or mid-issue immediately returns all outputs to their reset values; no partial instruction survives.

## Test plan
- Reset, then memory words 0x020A at addr 0 and 0x0242 at addr 1, zero wait, dec_ready=1:
  - Issues dec_instr=0x0000020A with dec_pc=0, then 0x00000242 with dec_pc=1.
  - dec_is32=0 both times; issue_count=2.
- Word 0x8123 at addr 4, then 0x8456 at addr 5:
  - One issue with dec_instr=0x84568123, dec_is32=1, dec_pc=4.
  - Next fetch address is 6.
- dec_ready=0 for 5 cycles in ISSUE: dec_valid stays 1, payload is unchanged, no imem_req. Then dec_ready=1 for 1 cycle: issue_count increments by 1.
- redirect=1 with redirect_pc=0x100 asserted during FETCH_HI with imem_ack=1 the same cycle:
  - Half-built instruction and ack are discarded; no dec_valid.
  - imem_req=0 for 1 cycle, then imem_addr=0x100.
- Memory with 3 wait states per fetch on a 32-bit instruction: dec_valid rises 8 cycles after the first imem_req.
- 32-bit instruction starting at 0xFFFFFF: second word fetched from 0x000000, dec_pc=0xFFFFFF, and the next fetch is at 0x000001.
- Async reset asserted mid-cycle in ISSUE: dec_valid falls without waiting for a clock edge.
